// File: rtl/lights_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lights_pkg
// Description : Shared constants and helpers for the LED colour sequencer:
//               default colour width, OFF code, legal MIN/MAX code helpers
//               and the direction encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lights_pkg;

  // Default colour code width per channel
  localparam int c_cw_default = 3;

  // Colour code meaning "LED off"
  localparam int c_colour_off = 0;

  // Direction encoding carried on the per-channel dir input
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Lowest legal colour code (a zero-width code has no legal value)
  function automatic int colour_min(input int cw);
    return (cw > 0) ? 1 : 0;
  endfunction

  // Highest legal colour code; the all-ones code is reserved as illegal
  function automatic int colour_max(input int cw);
    return (1 << cw) - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lights_chan.sv
`default_nettype none
// ============================================================================
// Module      : lights_chan
// Description : One LED channel: colour register, next-code logic and the
//               registered step/wrap pulses. Advances by one legal code per
//               qualifying update, wrapping MAX->MIN (up) or MIN->MAX (down).
//               Codes OFF and the all-ones illegal code recover to MIN/MAX
//               without signalling wrap. CW must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module lights_chan
  import lights_pkg::*;
#(
  parameter int CW = c_cw_default
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          upd_i,
  input  logic          dir_i,
  output logic [CW-1:0] colour_o,
  output logic          step_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] c_min = CW'(colour_min(CW));
  localparam logic [CW-1:0] c_max = CW'(colour_max(CW));
  localparam logic [CW-1:0] c_off = CW'(c_colour_off);
  localparam logic [CW-1:0] c_ill = '1;

  logic [CW-1:0] colour_q;
  logic [CW-1:0] colour_d;
  logic          step_q;
  logic          wrap_q;
  logic          wrap_d;

  // Next colour code and wrap flag for a qualifying update
  always_comb begin
    colour_d = colour_q;
    wrap_d   = 1'b0;
    if (upd_i) begin
      if (colour_q == c_off || colour_q == c_ill) begin
        // Recovery from off/illegal enters the legal range without a wrap
        colour_d = (dir_i == DIR_DOWN) ? c_max : c_min;
      end else if (dir_i == DIR_UP) begin
        if (colour_q == c_max) begin
          colour_d = c_min;
          wrap_d   = 1'b1;
        end else begin
          colour_d = colour_q + 1'b1;
        end
      end else begin
        if (colour_q == c_min) begin
          colour_d = c_max;
          wrap_d   = 1'b1;
        end else begin
          colour_d = colour_q - 1'b1;
        end
      end
    end
  end

  // Colour, step and wrap registers; step/wrap are single-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colour_q <= '0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      colour_q <= colour_d;
      step_q   <= upd_i;
      wrap_q   <= wrap_d;
    end
  end

  assign colour_o = colour_q;
  assign step_o   = step_q;
  assign wrap_o   = wrap_q;

endmodule
`default_nettype wire

// File: rtl/lights_seq.sv
`default_nettype none
// ============================================================================
// Module      : lights_seq
// Description : Multi-channel LED colour sequencer. A shared prescaler emits
//               a tick every div+1 cycles; each channel whose button is held
//               advances one colour code per tick in the direction given by
//               its dir bit.
//               Build option LIGHTS_SEQ_SYNC_EN: pass every button bit through
//               a two-flop synchroniser (two extra cycles of latency).
// Revision    : 1.0 - initial release
// ============================================================================
module lights_seq
  import lights_pkg::*;
#(
  parameter int CH    = 4,
  parameter int CW    = c_cw_default,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    button,
  input  logic [CH-1:0]    dir,
  input  logic [DIV_W-1:0] div,
  output logic [CH*CW-1:0] colour,
  output logic [CH-1:0]    step,
  output logic [CH-1:0]    wrap
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;
  logic             tick;
  logic [CH-1:0]    btn_w;

  // Using >= rather than == lets a lowered div fire on the next cycle
  // instead of waiting for the counter to roll over.
  assign tick    = (count_q >= div);
  assign count_d = tick ? '0 : count_q + 1'b1;

  // Shared prescaler counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

`ifdef LIGHTS_SEQ_SYNC_EN
  logic [CH-1:0] sync1_q;
  logic [CH-1:0] sync2_q;

  // Two-flop synchroniser for asynchronous button inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

  assign btn_w = sync2_q;
`else
  assign btn_w = button;
`endif

  for (genvar k = 0; k < CH; k++) begin : g_chan
    lights_chan #(
      .CW(CW)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .upd_i   (tick & btn_w[k]),
      .dir_i   (dir[k]),
      .colour_o(colour[k*CW +: CW]),
      .step_o  (step[k]),
      .wrap_o  (wrap[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_lights_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_lights_seq
// Description : Self-checking bench for lights_seq (CH=4, CW=3, DIV_W=8).
//               A reference model predicts every cycle's outputs into a
//               scoreboard queue; directed sequences add fixed-value checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lights_seq;

  localparam int CH    = 4;
  localparam int CW    = 3;
  localparam int DIV_W = 8;
`ifdef LIGHTS_SEQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk;
  logic             rst_n;
  logic [CH-1:0]    button;
  logic [CH-1:0]    dir;
  logic [DIV_W-1:0] div;
  logic [CH*CW-1:0] colour;
  logic [CH-1:0]    step;
  logic [CH-1:0]    wrap;

  lights_seq #(.CH(CH), .CW(CW), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .button(button),
    .dir   (dir),
    .div   (div),
    .colour(colour),
    .step  (step),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH*CW-1:0] col;
    logic [CH-1:0]    stp;
    logic [CH-1:0]    wrp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  logic [CW-1:0] m_col[CH];
  int            m_cnt;
`ifdef LIGHTS_SEQ_SYNC_EN
  logic [CH-1:0] m_s1;
  logic [CH-1:0] m_s2;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Legal codes 1..6 treated as a ring of six
  function automatic logic [CW-1:0] m_next(input logic [CW-1:0] c, input logic d,
                                           output logic w);
    int ci;
    ci = int'(c);
    if (ci == 0 || ci == 7) begin
      w = 1'b0;
      return d ? 3'd6 : 3'd1;
    end
    if (!d) begin
      w = (ci == 6);
      return CW'((ci % 6) + 1);
    end
    w = (ci == 1);
    return CW'(((ci + 4) % 6) + 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) m_col[k] = '0;
    m_cnt = 0;
`ifdef LIGHTS_SEQ_SYNC_EN
    m_s1 = '0;
    m_s2 = '0;
`endif
    sb.delete();
  endtask

  // Predict the outputs after the coming rising edge
  task automatic model_step(output exp_t e);
    logic [CH-1:0] be;
    logic          tk;
    logic          w;
`ifdef LIGHTS_SEQ_SYNC_EN
    be = m_s2;
`else
    be = button;
`endif
    tk    = (m_cnt >= int'(div));
    e.stp = '0;
    e.wrp = '0;
    for (int k = 0; k < CH; k++) begin
      if (tk && be[k]) begin
        m_col[k] = m_next(m_col[k], dir[k], w);
        e.stp[k] = 1'b1;
        e.wrp[k] = w;
      end
      e.col[k*CW +: CW] = m_col[k];
    end
    m_cnt = tk ? 0 : m_cnt + 1;
`ifdef LIGHTS_SEQ_SYNC_EN
    m_s2 = m_s1;
    m_s1 = button;
`endif
  endtask

  task automatic cyc();
    exp_t e;
    exp_t got;
    model_step(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("sb_colour", colour, got.col);
    check("sb_step", step, got.stp);
    check("sb_wrap", wrap, got.wrp);
  endtask

  task automatic do_reset(input logic [DIV_W-1:0] d, input logic [CH-1:0] b,
                          input logic [CH-1:0] dr);
    rst_n  = 1'b0;
    div    = d;
    button = b;
    dir    = dr;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_colour", colour, 0);
    check("rst_step", step, 0);
    check("rst_wrap", wrap, 0);
    rst_n = 1'b1;
  endtask

  // Hard stop in case anything stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [CW-1:0] seq[16];
  logic [CH-1:0] wv[16];
  logic [CH-1:0] sv[16];
  int            f;
  int            n;

  initial begin
    rst_n  = 1'b0;
    button = '0;
    dir    = '0;
    div    = '0;

    // Ascending walk on channel 0 with div = 0
    do_reset(8'd0, 4'b0001, 4'b0000);
    for (int i = 0; i < 12; i++) begin
      cyc();
      seq[i] = colour[CW-1:0];
      wv[i]  = wrap;
    end
    f = 0;
    for (int i = 11; i >= 0; i--) if (seq[i] != 0) f = i;
    check("first_update", f, LAT);
    for (int i = 0; i < 7; i++) begin
      check("asc_seq", seq[f+i], (i % 6) + 1);
      check("asc_wrap", wv[f+i][0], (i == 6));
    end

    // All channels stepping with div = 3
    do_reset(8'd3, 4'hF, 4'h0);
    for (int i = 0; i < 13; i++) begin
      cyc();
      sv[i] = step;
    end
    f = 99;
    for (int i = 12; i >= 0; i--) if (sv[i] == 4'hF) f = i;
    check("first_tick", f, 3);
    check("no_tick_5", sv[4], 0);
    check("tick_8", sv[7], 4'hF);
    check("tick_12", sv[11], 4'hF);

    // Descending on channel 1 from reset, then reverse
    do_reset(8'd0, 4'b0010, 4'b0010);
    for (int i = 0; i < LAT + 3; i++) begin
      cyc();
      seq[i] = colour[2*CW-1:CW];
      wv[i]  = wrap;
    end
    check("desc_first", seq[LAT], 6);
    check("desc_nowrap", wv[LAT][1], 0);
    check("desc_second", seq[LAT+1], 5);
    check("desc_third", seq[LAT+2], 4);
    dir = 4'b0000;
    cyc();
    check("rev_first", colour[2*CW-1:CW], 5);
    cyc();
    check("rev_second", colour[2*CW-1:CW], 6);

    // Freeze at colour 4 on release, resume at 5 on re-press
    do_reset(8'd3, 4'b0001, 4'b0000);
    n = 0;
    while (colour[CW-1:0] != 3'd4 && n < 100) begin
      cyc();
      n++;
    end
    check("reach_4", colour[CW-1:0], 4);
    button = 4'b0000;
    for (int i = 0; i < 50; i++) begin
      cyc();
      check("hold_colour", colour[CW-1:0], 4);
      check("hold_step", step[0], 0);
    end
    button = 4'b0001;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step[0] && n < 20);
    check("repress_step", step[0], 1);
    check("repress_colour", colour[CW-1:0], 5);

    // Asynchronous reset pulse between edges
    do_reset(8'd0, 4'hF, 4'b0101);
    repeat (5) cyc();
    #2 rst_n = 1'b0;
    #1;
    check("async_colour", colour, 0);
    check("async_step", step, 0);
    check("async_wrap", wrap, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cyc();

    // Random buttons, directions and divider changes
    do_reset(8'd2, 4'h0, 4'h0);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) button = CH'($urandom);
      if ($urandom_range(0, 5) == 0) dir = CH'($urandom);
      if ($urandom_range(0, 15) == 0) div = DIV_W'($urandom_range(0, 6));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
